pr3_fft_scheduler: RTL

- Frame-level round-robin scheduler that shares one streaming FFT engine between NSINK capture channels.
- Each channel's input buffer raises a request when it holds a complete 2^FFT-sample frame.
- The scheduler grants one channel, generates buffer read addresses and read enables, and emits Avalon-ST style valid/sop/eop framing plus a channel tag to the FFT sink.
- It releases the buffer when the frame has been read. Sits between the per-channel input buffers and the FFT core in the clk20 domain.

---
 rtl/pr3_fft_scheduler.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/pr3_fft_scheduler.sv
// Round-robin frame scheduler sharing one streaming FFT between NSINK capture buffers.
// Define PR3_SCHED_STATS_EN for frames_done/stall_cycles; the release pulse is buf_release (release is reserved).
module pr3_fft_scheduler #(
  parameter int NSINK  = 3,
  parameter int FFT    = 11,
  parameter int RD_LAT = 1,
  parameter int GAP    = 2
) (
  input  logic             clk20,
  input  logic             reset,
  input  logic [NSINK-1:0] req,
  input  logic             fft_ready,
  output logic [NSINK-1:0] grant,
  output logic             rd_en,
  output logic [FFT-1:0]   rd_addr,
  output logic [NSINK-1:0] buf_release,
  output logic             fft_valid,
  output logic             fft_sop,
  output logic             fft_eop,
`ifdef PR3_SCHED_STATS_EN
  output logic [15:0]      frames_done,
  output logic [15:0]      stall_cycles,
`endif
  output logic [2:0]       chan_id
);

  localparam logic [FFT-1:0] ADDR_MAX = '1;
  localparam int GAP_CYC = (GAP < 1) ? 1 : GAP;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, GAPW} state_t;

  typedef struct packed {
    logic       v;
    logic       s;
    logic       e;
    logic [2:0] ch;
  } tag_t;

  state_t           state_reg, state_next;
  logic [NSINK-1:0] grant_reg, grant_next;
  logic [NSINK-1:0] rel_reg, rel_next;
  logic [2:0]       gidx_reg, gidx_next;
  logic [2:0]       rr_reg, rr_next;
  logic [FFT-1:0]   addr_reg, addr_next;
  logic [3:0]       cnt_reg, cnt_next;
  logic [7:0]       req_ext;
  logic [7:0]       pick_oh;
  logic [2:0]       pick_idx;
  logic             pick_found;

  function automatic logic [2:0] wrap_idx(input logic [2:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NSINK) s = s - NSINK;
    return 3'(s);
  endfunction

  assign req_ext = 8'(req);

  // First requester at or after the rr pointer, searching upward modulo NSINK.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 0; k < NSINK; k++) begin
      if (!pick_found && req_ext[wrap_idx(rr_reg, k)]) begin
        pick_found = 1'b1;
        pick_idx   = wrap_idx(rr_reg, k);
      end
    end
  end

  assign pick_oh = 8'd1 << pick_idx;

  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    gidx_next  = gidx_reg;
    rr_next    = rr_reg;
    addr_next  = addr_reg;
    cnt_next   = cnt_reg;
    rel_next   = '0;
    rd_en      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (pick_found) begin
          grant_next = pick_oh[NSINK-1:0];
          gidx_next  = pick_idx;
          addr_next  = '0;
          state_next = RUN;
        end
      end
      RUN: begin
        rd_en = fft_ready;
        if (fft_ready) begin
          if (addr_reg == ADDR_MAX) begin
            state_next = DRAIN;
            cnt_next   = '0;
          end else begin
            addr_next = addr_reg + 1'b1;
          end
        end
      end
      DRAIN: begin
        // Release only once the last sample has left the read pipeline.
        if (cnt_reg == 4'(RD_LAT - 1)) begin
          rel_next   = grant_reg;
          grant_next = '0;
          rr_next    = (gidx_reg == 3'(NSINK - 1)) ? 3'd0 : gidx_reg + 3'd1;
          cnt_next   = '0;
          state_next = GAPW;
        end else begin
          cnt_next = cnt_reg + 4'd1;
        end
      end
      GAPW: begin
        if (cnt_reg == 4'(GAP_CYC - 1)) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg + 4'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk20) begin
    if (!reset) begin
      state_reg <= IDLE;
      grant_reg <= '0;
      gidx_reg  <= '0;
      rr_reg    <= '0;
      addr_reg  <= '0;
      cnt_reg   <= '0;
      rel_reg   <= '0;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      gidx_reg  <= gidx_next;
      rr_reg    <= rr_next;
      addr_reg  <= addr_next;
      cnt_reg   <= cnt_next;
      rel_reg   <= rel_next;
    end
  end

  assign grant       = grant_reg;
  assign rd_addr     = addr_reg;
  assign buf_release = rel_reg;

  // Framing travels alongside the buffer data, RD_LAT stages behind rd_en.
  tag_t pipe [RD_LAT+1];

  assign pipe[0] = '{v: rd_en,
                     s: rd_en && (addr_reg == '0),
                     e: rd_en && (addr_reg == ADDR_MAX),
                     ch: gidx_reg};

  generate
    for (genvar gi = 0; gi < RD_LAT; gi++) begin : g_lat
      always_ff @(posedge clk20) begin
        if (!reset) pipe[gi+1] <= '0;
        else        pipe[gi+1] <= pipe[gi];
      end
    end
  endgenerate

  assign fft_valid = pipe[RD_LAT].v;
  assign fft_sop   = pipe[RD_LAT].s;
  assign fft_eop   = pipe[RD_LAT].e;
  assign chan_id   = pipe[RD_LAT].ch;

`ifdef PR3_SCHED_STATS_EN
  logic [15:0] frames_reg, stall_reg;

  always_ff @(posedge clk20) begin
    if (!reset) begin
      frames_reg <= '0;
      stall_reg  <= '0;
    end else begin
      if (|rel_next) frames_reg <= frames_reg + 16'd1;
      if (state_reg == RUN && !fft_ready) stall_reg <= stall_reg + 16'd1;
    end
  end

  assign frames_done  = frames_reg;
  assign stall_cycles = stall_reg;
`endif

endmodule
